sub8u_serial_checker: RTL and testbench

// Bit-serial unsigned subtractor and checker that runs the adder path in reverse.

---
 rtl/sub8u_serial_checker_if.sv | 29 ++
 rtl/sub8u_serial_checker.sv | 136 +++++++++++++
 tb/tb_sub8u_serial_checker.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sub8u_serial_checker_if.sv
// Handshake bundle for the bit-serial subtract-and-compare checker:
// operand-triple input, result output, and mismatch-counter control.
interface sub8u_serial_checker_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             mismatch;
  logic [CNT_W-1:0] err_count;
  logic             clr_count;

  modport master (
    output in_valid, a, b, sum, out_ready, clr_count,
    input  in_ready, out_valid, diff, borrow, mismatch, err_count
  );

  modport slave (
    input  in_valid, a, b, sum, out_ready, clr_count,
    output in_ready, out_valid, diff, borrow, mismatch, err_count
  );
endinterface

// File: rtl/sub8u_serial_checker.sv
// Fault monitor for an unsigned adder: recovers sum - b one bit per cycle
// and flags results whose difference does not reproduce operand a.
//
// state | meaning
// IDLE  | ready for an operand triple
// SUB   | one difference bit per cycle, LSB first, WIDTH+1 bits
// DONE  | diff/borrow/mismatch valid, waiting for out_ready
module sub8u_serial_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  sub8u_serial_checker_if.slave bus
);

  localparam int KW = $clog2(WIDTH + 1);
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH:0]   b_sh_q;
  logic [WIDTH:0]   sum_sh_q;
  logic [WIDTH-1:0] work_q;
  logic [KW-1:0]    k_q;
  logic             br_q;
  logic [WIDTH:0]   diff_q;
  logic             borrow_q;
  logic             mismatch_q;
  logic [CNT_W-1:0] cnt_q;

  logic             in_ready_c;
  logic             out_valid_c;
  logic             accept;
  logic             handshake;
  logic             last_bit;
  logic             s_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH:0]   diff_final;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = SUB;
      end
      SUB: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = in_ready_c & bus.in_valid;
  assign handshake = out_valid_c & bus.out_ready;
  assign last_bit  = (state_q == SUB) && (k_q == K_LAST);

  // Operands are shifted right so the current bit is always at position 0;
  // b carries a zero in its top position, matching b[WIDTH]=0.
  assign s_bit      = sum_sh_q[0];
  assign b_bit      = b_sh_q[0];
  assign d_bit      = s_bit ^ b_bit ^ br_q;
  assign br_next    = (~s_bit & b_bit) | (~(s_bit ^ b_bit) & br_q);
  assign diff_final = {d_bit, work_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_sh_q     <= '0;
      sum_sh_q   <= '0;
      work_q     <= '0;
      k_q        <= '0;
      br_q       <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      mismatch_q <= 1'b0;
    end else if (accept) begin
      a_q      <= bus.a;
      b_sh_q   <= {1'b0, bus.b};
      sum_sh_q <= bus.sum;
      k_q      <= '0;
      br_q     <= 1'b0;
    end else if (state_q == SUB) begin
      work_q   <= {d_bit, work_q[WIDTH-1:1]};
      b_sh_q   <= {1'b0, b_sh_q[WIDTH:1]};
      sum_sh_q <= {1'b0, sum_sh_q[WIDTH:1]};
      br_q     <= br_next;
      k_q      <= k_q + KW'(1);
      // Results are published only once complete so they hold outside DONE.
      if (last_bit) begin
        diff_q     <= diff_final;
        borrow_q   <= br_next;
        mismatch_q <= br_next | (diff_final != {1'b0, a_q});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.clr_count) begin
      cnt_q <= '0;
    end else if (handshake && mismatch_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.err_count = cnt_q;

endmodule

// File: tb/tb_sub8u_serial_checker.sv
// Directed bench for sub8u_serial_checker: a 16-bit and a 4-bit counter
// instance run the same stimulus in lockstep.
module tb_sub8u_serial_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sub8u_serial_checker_if #(.WIDTH(8), .CNT_W(16)) bus ();
  sub8u_serial_checker_if #(.WIDTH(8), .CNT_W(4))  bus4 ();

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.a         = bus.a;
  assign bus4.b         = bus.b;
  assign bus4.sum       = bus.sum;
  assign bus4.out_ready = bus.out_ready;
  assign bus4.clr_count = bus.clr_count;

  sub8u_serial_checker #(.WIDTH(8), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sub8u_serial_checker #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] sum;
    logic [8:0] diff;
    logic       borrow;
    logic       mm;
  } vec_t;

  vec_t vecs [12];

  int passed = 0;
  int total  = 0;
  logic [15:0] exp_cnt  = '0;
  logic [3:0]  exp_cnt4 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_hs(input logic mm, input logic clr);
    if (clr) begin
      exp_cnt  = '0;
      exp_cnt4 = '0;
    end else if (mm) begin
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      if (exp_cnt4 != 4'hF)    exp_cnt4 = exp_cnt4 + 4'd1;
    end
  endtask

  task automatic check_counts(input string name);
    check({name, "_cnt16"}, 32'(bus.err_count), 32'(exp_cnt));
    check({name, "_cnt4"},  32'(bus4.err_count), 32'(exp_cnt4));
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [8:0] sum,
                         input logic [8:0] ediff, input logic eb, input logic em,
                         input int hold, input logic clr);
    int n;
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.sum = sum;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = ~a;
    bus.b = ~b;
    bus.sum = ~sum;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) check("in_ready_sub", 32'(bus.in_ready), 32'd0);
    end while (!bus.out_valid && n <= 20);
    check("latency", 32'(n), 32'd9);
    if (!bus.out_valid) return;
    check("diff", 32'(bus.diff), 32'(ediff));
    check("borrow", 32'(bus.borrow), 32'(eb));
    check("mismatch", 32'(bus.mismatch), 32'(em));
    check("in_ready_done", 32'(bus.in_ready), 32'd0);
    check_counts("pre_hs");
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_diff", 32'(bus.diff), 32'(ediff));
      check("hold_mismatch", 32'(bus.mismatch), 32'(em));
      check_counts("hold");
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.clr_count = clr;
    @(posedge clk);
    #1;
    model_hs(em, clr);
    bus.out_ready = 1'b0;
    bus.clr_count = 1'b0;
    check("post_hs_valid", 32'(bus.out_valid), 32'd0);
    check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_hs_diff_holds", 32'(bus.diff), 32'(ediff));
    check_counts("post_hs");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{8'h5A, 8'h3C, 9'h096, 9'h05A, 1'b0, 1'b0};
    vecs[1]  = '{8'h5A, 8'h3C, 9'h097, 9'h05B, 1'b0, 1'b1};
    vecs[2]  = '{8'hFF, 8'hFF, 9'h1FE, 9'h0FF, 1'b0, 1'b0};
    vecs[3]  = '{8'h00, 8'h01, 9'h000, 9'h1FF, 1'b1, 1'b1};
    vecs[4]  = '{8'h00, 8'h00, 9'h000, 9'h000, 1'b0, 1'b0};
    vecs[5]  = '{8'h80, 8'h80, 9'h100, 9'h080, 1'b0, 1'b0};
    vecs[6]  = '{8'h12, 8'h34, 9'h046, 9'h012, 1'b0, 1'b0};
    vecs[7]  = '{8'h12, 8'h34, 9'h146, 9'h112, 1'b0, 1'b1};
    vecs[8]  = '{8'h01, 8'hFF, 9'h0FF, 9'h000, 1'b0, 1'b1};
    vecs[9]  = '{8'hAA, 8'h55, 9'h0FF, 9'h0AA, 1'b0, 1'b0};
    vecs[10] = '{8'h00, 8'hFF, 9'h0FE, 9'h1FF, 1'b1, 1'b1};
    vecs[11] = '{8'hFF, 8'h00, 9'h0FF, 9'h0FF, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sum       = '0;
    bus.out_ready = 1'b0;
    bus.clr_count = 1'b0;
    rst_n         = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_borrow", 32'(bus.borrow), 32'd0);
    check("rst_mismatch", 32'(bus.mismatch), 32'd0);
    check_counts("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Vector 1 also sits in DONE for 5 cycles of back-pressure.
    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].diff,
              vecs[i].borrow, vecs[i].mm, (i == 1) ? 5 : 0, 1'b0);
    end

    for (int i = 0; i < 20; i++) begin
      run_txn(8'h5A, 8'h3C, 9'h097, 9'h05B, 1'b0, 1'b1, 0, 1'b0);
    end
    check("sat_cnt4", 32'(bus4.err_count), 32'd15);
    check("cnt16_total", 32'(bus.err_count), 32'd25);

    run_txn(8'h5A, 8'h3C, 9'h097, 9'h05B, 1'b0, 1'b1, 0, 1'b1);
    check("clr_wins", 32'(bus.err_count), 32'd0);

    // Reset while SUB is processing bit 3.
    run_txn(8'h00, 8'h01, 9'h000, 9'h1FF, 1'b1, 1'b1, 0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 8'h5A;
    bus.b = 8'h3C;
    bus.sum = 9'h096;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_hs(1'b0, 1'b1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_diff", 32'(bus.diff), 32'd0);
    check_counts("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(8'h12, 8'h34, 9'h046, 9'h012, 1'b0, 1'b0, 0, 1'b0);

    run_txn(8'h12, 8'h34, 9'h146, 9'h112, 1'b0, 1'b1, 2, 1'b0);
    @(negedge clk);
    bus.clr_count = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_count = 1'b0;
    model_hs(1'b0, 1'b1);
    check_counts("idle_clr");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
